axi_lite_boot_loader: RTL and testbench

- AXI4-Lite master that sits directly upstream of the core's AXI-Lite slave port. It drives that port to load instruction memory (0x000–0x7FF) and data memory (0x800–0xFFF) before and while the CPU runs.
- It accepts (address, data) words on a valid/ready command stream from a boot source (UART/ROM), buffers them in a small FIFO, and issues one AXI-Lite write per word.
- It optionally reads each word back and compares it, then reports done/error status.

---
 rtl/axi_lite_boot_loader.sv | 220 ++++++++++++++++++++++
 tb/tb_axi_lite_boot_loader.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_boot_loader.sv
// AXI4-Lite write master that drains a small (addr, data) command FIFO into the core's
// slave port. It can read each word back to verify it and reports done/error status.
module axi_lite_boot_loader #(
  parameter int FIFO_AW = 2,
  parameter bit VERIFY  = 1'b1,
  parameter int TIMEOUT = 255
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [11:0] cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic        cmd_last,
  input  logic        err_clr,
  output logic [11:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [11:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [11:0] err_addr,
  output logic [15:0] word_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_WADDR, S_WRESP, S_RADDR, S_RDATA} state_t;
  typedef enum logic [1:0] {
    E_NONE = 2'b00, E_RESP = 2'b01, E_MISMATCH = 2'b10, E_TIMEOUT = 2'b11
  } err_t;
  typedef struct packed {
    logic        last;
    logic [11:0] addr;
    logic [31:0] data;
  } cmd_t;

  localparam int         DEPTH    = 1 << FIFO_AW;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t           state;
  cmd_t             fifo_mem [DEPTH];
  cmd_t             head;
  cmd_t             cur;
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  logic             alive;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             flush;
  logic             aw_valid;
  logic             w_valid;
  logic             b_ready;
  logic             ar_valid;
  logic             r_ready;
  logic [7:0]       tmo_cnt;
  logic             step_done;
  err_t             fault;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                     (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign cmd_ready = alive & ~full & ~error;
  assign push      = cmd_valid & cmd_ready;
  assign flush     = err_clr & (state == S_IDLE);
  assign pop       = (state == S_IDLE) & ~empty & ~error & ~flush;
  assign head      = fifo_mem[rd_ptr[FIFO_AW-1:0]];
  assign busy      = ~empty | (state != S_IDLE);

  assign M_AXI_AWADDR  = cur.addr;
  assign M_AXI_ARADDR  = cur.addr;
  assign M_AXI_WDATA   = cur.data;
  assign M_AXI_WSTRB   = 4'b1111;
  assign M_AXI_AWVALID = aw_valid;
  assign M_AXI_WVALID  = w_valid;
  assign M_AXI_BREADY  = b_ready;
  assign M_AXI_ARVALID = ar_valid;
  assign M_AXI_RREADY  = r_ready;

  // Holds cmd_ready low until the first clock after reset release.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) alive <= 1'b0;
    else                alive <= 1'b1;
  end

  // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge S_AXI_ACLK) begin
    if (push)
      fifo_mem[wr_ptr[FIFO_AW-1:0]] <= '{last: cmd_last, addr: cmd_addr & 12'hFFC, data: cmd_data};
  end

  // NOTE: sequential state uses <= so every flop samples the pre-edge values.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + {{FIFO_AW{1'b0}}, push};
      if (flush)    rd_ptr <= wr_ptr;
      else if (pop) rd_ptr <= rd_ptr + {{FIFO_AW{1'b0}}, 1'b1};
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    step_done = 1'b0;
    fault     = E_NONE;
    case (state)
      S_WADDR: step_done = (~aw_valid | M_AXI_AWREADY) & (~w_valid | M_AXI_WREADY);
      S_WRESP: begin
        step_done = M_AXI_BVALID;
        if (M_AXI_BVALID && M_AXI_BRESP != 2'b00) fault = E_RESP;
      end
      S_RADDR: step_done = M_AXI_ARREADY;
      S_RDATA: begin
        step_done = M_AXI_RVALID;
        if (M_AXI_RVALID) begin
          if (M_AXI_RRESP != 2'b00)          fault = E_RESP;
          else if (M_AXI_RDATA != cur.data) fault = E_MISMATCH;
        end
      end
      default: ;
    endcase
    if (state != S_IDLE && !step_done && tmo_cnt == TMO_LAST) fault = E_TIMEOUT;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state    <= S_IDLE;
      cur      <= '0;
      aw_valid <= 1'b0;
      w_valid  <= 1'b0;
      b_ready  <= 1'b0;
      ar_valid <= 1'b0;
      r_ready  <= 1'b0;
      tmo_cnt  <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_code <= E_NONE;
      err_addr <= '0;
      word_cnt <= '0;
    end else begin
      done    <= 1'b0;
      tmo_cnt <= (state == S_IDLE || step_done) ? 8'd0 : tmo_cnt + 8'd1;
      if (flush) begin
        error    <= 1'b0;
        err_code <= E_NONE;
        err_addr <= '0;
      end
      if (fault != E_NONE) begin
        error    <= 1'b1;
        err_code <= fault;
        err_addr <= cur.addr;
        aw_valid <= 1'b0;
        w_valid  <= 1'b0;
        b_ready  <= 1'b0;
        ar_valid <= 1'b0;
        r_ready  <= 1'b0;
        state    <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (pop) begin
            cur      <= head;
            aw_valid <= 1'b1;
            w_valid  <= 1'b1;
            state    <= S_WADDR;
          end
          S_WADDR: begin
            // AW and W retire independently; whichever handshakes first drops alone.
            if (M_AXI_AWREADY) aw_valid <= 1'b0;
            if (M_AXI_WREADY)  w_valid  <= 1'b0;
            if (step_done) begin
              b_ready <= 1'b1;
              state   <= S_WRESP;
            end
          end
          S_WRESP: if (M_AXI_BVALID) begin
            b_ready <= 1'b0;
            if (VERIFY) begin
              ar_valid <= 1'b1;
              state    <= S_RADDR;
            end else begin
              word_cnt <= word_cnt + 16'd1;
              done     <= cur.last;
              state    <= S_IDLE;
            end
          end
          S_RADDR: if (M_AXI_ARREADY) begin
            ar_valid <= 1'b0;
            r_ready  <= 1'b1;
            state    <= S_RDATA;
          end
          S_RDATA: if (M_AXI_RVALID) begin
            r_ready  <= 1'b0;
            word_cnt <= word_cnt + 16'd1;
            done     <= cur.last;
            state    <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_boot_loader.sv
// Directed bench for axi_lite_boot_loader: a configurable AXI-Lite memory slave plus a
// linear sequence of load, stall, mismatch, timeout and reset scenarios.
module tb_axi_lite_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [11:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic        cmd_last = 1'b0;
  logic        err_clr = 1'b0;
  logic [11:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;
  logic [11:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [11:0] err_addr;
  logic [15:0] word_cnt;

  always #5 clk = ~clk;

  axi_lite_boot_loader dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_last(cmd_last), .err_clr(err_clr),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(2'b00), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(2'b00), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .err_addr(err_addr), .word_cnt(word_cnt)
  );

  // Slave knobs, driven from the stimulus thread.
  int          aw_lat = 0;
  int          w_lat = 0;
  bit          stall = 1'b0;
  bit          b_hold = 1'b0;
  bit          corrupt = 1'b0;
  logic [11:0] corrupt_addr = 12'h800;

  // Slave state.
  int          aw_wait;
  int          w_wait;
  logic        aw_got;
  logic        w_got;
  logic [11:0] aw_addr_q;
  logic [31:0] w_data_q;
  logic [31:0] smem [1024];
  logic [43:0] wlog [$];

  wire         aw_hs  = awvalid & awready;
  wire         w_hs   = wvalid & wready;
  wire         have_aw = aw_got | aw_hs;
  wire         have_w  = w_got | w_hs;
  wire  [11:0] c_addr = aw_got ? aw_addr_q : awaddr;
  wire  [31:0] c_data = w_got ? w_data_q : wdata;

  assign awready = awvalid && !stall && (aw_wait >= aw_lat);
  assign wready  = wvalid && !stall && (w_wait >= w_lat);
  assign arready = arvalid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_wait <= 0;
      w_wait  <= 0;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      bvalid  <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
    end else begin
      aw_wait <= aw_hs ? 0 : (awvalid ? aw_wait + 1 : aw_wait);
      w_wait  <= w_hs ? 0 : (wvalid ? w_wait + 1 : w_wait);
      if (have_aw && have_w) begin
        smem[c_addr[11:2]] <= c_data;
        wlog.push_back({c_addr, c_data});
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        if (!b_hold) bvalid <= 1'b1;
      end else begin
        if (aw_hs) begin aw_got <= 1'b1; aw_addr_q <= awaddr; end
        if (w_hs)  begin w_got  <= 1'b1; w_data_q  <= wdata;  end
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rdata  <= smem[araddr[11:2]] ^ ((corrupt && araddr == corrupt_addr) ? 32'h1 : 32'h0);
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  // Cycle monitors sampled away from the active edge.
  int   done_cnt = 0;
  int   aw_cycles = 0;
  int   w_cycles = 0;
  int   b_cycles = 0;
  int   viol = 0;
  logic p_aw = 1'b0;
  logic p_w = 1'b0;
  logic p_ar = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (done)    done_cnt++;
      if (awvalid) aw_cycles++;
      if (wvalid)  w_cycles++;
      if (bready)  b_cycles++;
      if (!error && ((p_aw && !awvalid) || (p_w && !wvalid) || (p_ar && !arvalid))) viol++;
    end
    p_aw = rst_n && awvalid && !awready;
    p_w  = rst_n && wvalid && !wready;
    p_ar = rst_n && arvalid && !arready;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [11:0] a, input logic [31:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = a; cmd_data = d; cmd_last = l;
    while (!cmd_ready && n < 1000) begin @(negedge clk); n++; end
    check($sformatf("push_ready_%0h", a), n < 1000, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0; cmd_last = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (busy && n < 2000) begin @(negedge clk); n++; end
    check({tag, "_idle_bound"}, n < 2000, 1);
    @(negedge clk);
  endtask

  task automatic wait_error(input string tag);
    int n = 0;
    @(negedge clk);
    while (!error && n < 2000) begin @(negedge clk); n++; end
    check({tag, "_error_bound"}, n < 2000, 1);
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int d0;
    int a0;
    int w0;
    int b0;
    int acc;
    int n;
    logic [43:0] exp;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_cmd_ready", cmd_ready, 0);
    check("reset_outputs", {awvalid, wvalid, bready, arvalid, rready, busy, done, error,
                            err_code, err_addr, word_cnt, awaddr}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", cmd_ready, 1);

    // 1: image of 7 instruction words plus one data word.
    base = wlog.size(); d0 = done_cnt;
    for (int i = 0; i < 7; i++) push(12'(i * 4), 32'h1000_0000 + i, 1'b0);
    push(12'h800, 32'hdeadbeef, 1'b1);
    wait_idle("img");
    check("img_writes", wlog.size() - base, 8);
    for (int i = 0; i < 8; i++) begin
      exp = (i < 7) ? {12'(i * 4), 32'h1000_0000 + i} : {12'h800, 32'hdeadbeef};
      check($sformatf("img_write_%0d", i), (wlog.size() > base + i) ? wlog[base + i] : 44'h0, exp);
    end
    check("img_word_cnt", word_cnt, 8);
    check("img_done", done_cnt - d0, 1);
    check("img_error", error, 0);

    // 2: AWREADY after 3 wait cycles, WREADY after 1.
    aw_lat = 3; w_lat = 1;
    base = wlog.size(); a0 = aw_cycles; w0 = w_cycles;
    push(12'h020, 32'h1234_5678, 1'b0);
    wait_idle("slow");
    check("slow_aw_cycles", aw_cycles - a0, 4);
    check("slow_w_cycles", w_cycles - w0, 2);
    check("slow_writes", wlog.size() - base, 1);
    check("slow_entry", (wlog.size() > base) ? wlog[base] : 44'h0, {12'h020, 32'h1234_5678});
    check("slow_word_cnt", word_cnt, 9);
    aw_lat = 0; w_lat = 0;

    // 3: readback mismatch at 0x800.
    corrupt = 1'b1; d0 = done_cnt;
    push(12'h800, 32'hdeadbeef, 1'b1);
    wait_idle("mis");
    check("mis_error", error, 1);
    check("mis_code", err_code, 2'b10);
    check("mis_addr", err_addr, 12'h800);
    check("mis_no_done", done_cnt - d0, 0);
    check("mis_cmd_ready", cmd_ready, 0);
    check("mis_word_cnt", word_cnt, 9);
    corrupt = 1'b0;
    pulse_clr();
    check("clr_status", {error, err_code, err_addr}, 0);
    check("clr_cmd_ready", cmd_ready, 1);

    // 4: slave never answers B; a second word waits in the FIFO.
    b_hold = 1'b1; b0 = b_cycles;
    push(12'h030, 32'hcafe_0030, 1'b0);
    push(12'h034, 32'hcafe_0034, 1'b0);
    wait_error("tmo");
    check("tmo_code", err_code, 2'b11);
    check("tmo_addr", err_addr, 12'h030);
    check("tmo_bready_cycles", b_cycles - b0, 255);
    check("tmo_handshakes_low", {bready, awvalid, wvalid, arvalid, rready}, 0);
    check("tmo_cmd_ready", cmd_ready, 0);
    check("tmo_busy_fifo", busy, 1);
    b_hold = 1'b0;
    pulse_clr();
    check("tmo_clr_ready", cmd_ready, 1);
    check("tmo_clr_flushed", {busy, error}, 0);
    check("tmo_word_cnt", word_cnt, 9);

    // 5: back-to-back pushes against a stalled slave.
    stall = 1'b1; base = wlog.size(); d0 = done_cnt; acc = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (acc < 6) begin
        cmd_valid = 1'b1; cmd_addr = 12'h100 + 12'(acc * 4);
        cmd_data = 32'h5000_0000 + acc; cmd_last = (acc == 5);
        if (cmd_ready) acc++;
      end
    end
    check("stall_accepted", acc, 5);
    check("stall_cmd_ready", cmd_ready, 0);
    @(negedge clk); cmd_valid = 1'b0; cmd_last = 1'b0;
    stall = 1'b0;
    push(12'h114, 32'h5000_0005, 1'b1);
    wait_idle("stall");
    check("stall_writes", wlog.size() - base, 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("stall_write_%0d", i), (wlog.size() > base + i) ? wlog[base + i] : 44'h0,
            {12'h100 + 12'(i * 4), 32'h5000_0000 + i});
    check("stall_word_cnt", word_cnt, 15);
    check("stall_done", done_cnt - d0, 1);

    // 6: reset while AW/W are pending.
    stall = 1'b1;
    push(12'h200, 32'haaaa_0200, 1'b0);
    n = 0;
    while (!awvalid && n < 100) begin @(negedge clk); n++; end
    check("rst_reached_waddr", awvalid, 1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("rst_async_outputs", {awvalid, wvalid, bready, arvalid, rready, cmd_ready, busy,
                                done, error, word_cnt}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; stall = 1'b0;
    base = wlog.size(); d0 = done_cnt;
    push(12'h000, 32'h0bad_0000, 1'b0);
    push(12'h004, 32'h0bad_0004, 1'b0);
    push(12'h800, 32'h0bad_d800, 1'b1);
    wait_idle("reload");
    check("reload_writes", wlog.size() - base, 3);
    check("reload_last", (wlog.size() > base + 2) ? wlog[base + 2] : 44'h0, {12'h800, 32'h0bad_d800});
    check("reload_word_cnt", word_cnt, 3);
    check("reload_done", done_cnt - d0, 1);
    check("reload_error", error, 0);
    check("valid_rule_violations", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
